// File: rtl/pir_alarm_multi_core.sv
`default_nettype none
// ============================================================================
// Module      : pir_alarm_multi_core
// Description : Multi-channel PIR alarm controller (sync, debounce, FSM, buzzer)
// Revision    : 1.0 - initial release
// ============================================================================
module pir_alarm_multi_core #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int COOLDOWN_CYCLES = 10000000,
    parameter int BUZZ_HALF       = 25000
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_areset,
    input  logic [NUM_CH-1:0] pir_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              arm,
    input  logic              latch_mode,
    input  logic              clear,
    output logic              led,
    output logic              buzzer,
    output logic              enable_capture,
    output logic              alarm_active,
    output logic [NUM_CH-1:0] trig_status,
    output logic [15:0]       event_count
);

    localparam int TMR_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BUZZ_W  = $clog2(BUZZ_HALF + 1);

    localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  COOL_LAST = TMR_W'(COOLDOWN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_HALF - 1);

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ALARM    = 3'd2;
    localparam logic [2:0] ST_COOLDOWN = 3'd3;
    localparam logic [2:0] ST_LATCHED  = 3'd4;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] trig;
    logic              any;

    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    // ------------------------------------------------------------------------
    // Per-channel synchroniser, debounce and rising-edge detector
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             deb_q, deb_d;
        logic             deb_dly_q;
        logic [DEB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == DEB_LAST) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                deb_q     <= 1'b0;
                deb_dly_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= pir_in[g];
                sync2_q   <= sync1_q;
                deb_q     <= deb_d;
                deb_dly_q <= deb_q;
                cnt_q     <= cnt_d;
            end
        end

        assign trig[g] = deb_q & ~deb_dly_q & ch_enable[g];
    end

    assign any = |trig;

    // ------------------------------------------------------------------------
    // Alarm state machine, shared hold/cooldown timer
    // ------------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic              buzzer_q, buzzer_d;
    logic              led_q, led_d;
    logic              alarm_q, alarm_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [15:0]       count_q, count_d;
    logic              accept;
    logic              set_ok;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (!arm) begin
            state_d = ST_DISARMED;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (any) begin
                        state_d = ST_ALARM;
                        tmr_d   = HOLD_LAST;
                    end
                end
                ST_ALARM: begin
                    if (any) begin
                        tmr_d = HOLD_LAST;
                    end else if (tmr_q == '0) begin
                        state_d = latch_mode ? ST_LATCHED : ST_COOLDOWN;
                        tmr_d   = latch_mode ? '0 : COOL_LAST;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (tmr_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_LATCHED: begin
                    if (clear) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Counting and status setting follow the state the trigger was seen in.
    always_comb begin
        accept   = arm && any && ((state_q == ST_IDLE) || (state_q == ST_ALARM));
        set_ok   = arm && ((state_q == ST_IDLE) || (state_q == ST_ALARM) || (state_q == ST_LATCHED));
        count_d  = count_q;
        if (accept && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
        status_d = (status_q & ~{NUM_CH{clear}}) | (set_ok ? trig : '0);
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        led_d      = (state_d == ST_ALARM) || (state_d == ST_LATCHED);
        alarm_d    = (state_d == ST_ALARM);
        buzzer_d   = 1'b0;
        buzz_cnt_d = '0;
        if (state_d == ST_ALARM) begin
            if (state_q != ST_ALARM) begin
                buzzer_d = 1'b1;
            end else if (buzz_cnt_q == BUZZ_LAST) begin
                buzzer_d = ~buzzer_q;
            end else begin
                buzzer_d   = buzzer_q;
                buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DISARMED;
            tmr_q      <= '0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            led_q      <= 1'b0;
            alarm_q    <= 1'b0;
            status_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
            led_q      <= led_d;
            alarm_q    <= alarm_d;
            status_q   <= status_d;
            count_q    <= count_d;
        end
    end

    assign led            = led_q;
    assign buzzer         = buzzer_q;
    assign enable_capture = alarm_q;
    assign alarm_active   = alarm_q;
    assign trig_status    = status_q;
    assign event_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pir_alarm_multi_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pir_alarm_multi_core
// Description : Directed bench for pir_alarm_multi_core (small parameters)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pir_alarm_multi_core;

    logic       clk;
    logic       rst;
    logic [3:0] pir_in;
    logic [3:0] ch_enable;
    logic       arm;
    logic       latch_mode;
    logic       clear;
    logic       led;
    logic       buzzer;
    logic       enable_capture;
    logic       alarm_active;
    logic [3:0] trig_status;
    logic [15:0] event_count;

    int compared   = 0;
    int mismatched = 0;

    pir_alarm_multi_core #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .COOLDOWN_CYCLES (8),
        .BUZZ_HALF       (2)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .pir_in         (pir_in),
        .ch_enable      (ch_enable),
        .arm            (arm),
        .latch_mode     (latch_mode),
        .clear          (clear),
        .led            (led),
        .buzzer         (buzzer),
        .enable_capture (enable_capture),
        .alarm_active   (alarm_active),
        .trig_status    (trig_status),
        .event_count    (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic l, input logic b, input logic e, input logic a);
        chk({tag, "_led"}, {31'd0, led}, {31'd0, l});
        chk({tag, "_buzzer"}, {31'd0, buzzer}, {31'd0, b});
        chk({tag, "_capture"}, {31'd0, enable_capture}, {31'd0, e});
        chk({tag, "_alarm"}, {31'd0, alarm_active}, {31'd0, a});
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; pir_in = 4'b0000; ch_enable = 4'b1111;
        latch_mode = 1'b0; clear = 1'b0;
        tick(); tick();
        chk_outs("reset", 0, 0, 0, 0);
        chk("reset_count", {16'd0, event_count}, 32'd0);
        chk("reset_status", {28'd0, trig_status}, 32'd0);

        rst = 1'b0; arm = 1'b1;
        tick(); tick(); tick();
        chk_outs("idle", 0, 0, 0, 0);

        // Channel 0 held high 20 cycles; E0 is the first sampling edge.
        pir_in = 4'b0001;
        repeat (6) tick();
        chk("latency_pre", {31'd0, alarm_active}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("hold_alarm", {31'd0, alarm_active}, 32'd1);
            chk("hold_led", {31'd0, led}, 32'd1);
            chk("hold_capture", {31'd0, enable_capture}, 32'd1);
            chk("buzz_pattern", {31'd0, buzzer}, (((i / 2) % 2) == 0) ? 32'd1 : 32'd0);
            if (i == 13) pir_in[0] = 1'b0;
        end
        tick(); // E22
        chk_outs("cooldown", 0, 0, 0, 0);
        chk("count_first", {16'd0, event_count}, 32'd1);
        chk("status_first", {28'd0, trig_status}, 32'd1);

        // ch1 lands on the last cooldown edge, ch3 on the first idle edge.
        tick();           // E23
        pir_in[1] = 1'b1;
        tick();           // E24
        pir_in[3] = 1'b1;
        repeat (6) tick(); // E30
        chk("cool_last_alarm", {31'd0, alarm_active}, 32'd0);
        chk("cool_ignore_count", {16'd0, event_count}, 32'd1);
        chk("cool_ignore_status", {28'd0, trig_status}, 32'd1);
        tick();           // E31
        chk("idle_after_cool", {31'd0, alarm_active}, 32'd1);
        chk("count_second", {16'd0, event_count}, 32'd2);
        chk("status_second", {28'd0, trig_status}, 32'h9);

        // Retrigger on ch2 seen at hold count 3 (edge E44).
        repeat (6) tick(); // E37
        pir_in[2] = 1'b1;
        repeat (8) tick(); // E45
        chk("buzz_no_restart", {31'd0, buzzer}, 32'd0);
        tick();           // E46
        chk("retrig_hold0", {31'd0, alarm_active}, 32'd1);
        tick();           // E47
        chk("retrig_extended", {31'd0, alarm_active}, 32'd1);
        chk("count_retrig", {16'd0, event_count}, 32'd3);
        chk("status_retrig", {28'd0, trig_status}, 32'hD);
        pir_in = 4'b0000;
        repeat (12) tick(); // E59
        chk("retrig_last", {31'd0, alarm_active}, 32'd1);
        tick();           // E60
        chk("retrig_end", {31'd0, alarm_active}, 32'd0);
        repeat (10) tick();

        // 3-cycle glitch is rejected.
        pir_in[1] = 1'b1;
        repeat (3) tick();
        pir_in[1] = 1'b0;
        repeat (10) tick();
        chk("glitch_alarm", {31'd0, alarm_active}, 32'd0);
        chk("glitch_count", {16'd0, event_count}, 32'd3);

        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_idle", {28'd0, trig_status}, 32'd0);

        // 4-cycle pulses on ch0 and ch3 together: one event, two status bits.
        pir_in = 4'b1001;
        repeat (4) tick();
        pir_in = 4'b0000;
        tick(); tick();   // E5
        chk("dual_pre", {31'd0, alarm_active}, 32'd0);
        tick();           // E6
        chk("dual_alarm", {31'd0, alarm_active}, 32'd1);
        chk("dual_count", {16'd0, event_count}, 32'd4);
        chk("dual_status", {28'd0, trig_status}, 32'h9);

        latch_mode = 1'b1;
        repeat (15) tick(); // E21
        chk("latch_pre", {31'd0, alarm_active}, 32'd1);
        tick();           // E22
        chk_outs("latched", 1, 0, 0, 0);
        repeat (5) tick();
        chk_outs("latched_hold", 1, 0, 0, 0);
        pir_in[1] = 1'b1;
        repeat (6) tick();
        pir_in[1] = 1'b0;
        tick();
        chk("latch_status", {28'd0, trig_status}, 32'hB);
        chk("latch_count", {16'd0, event_count}, 32'd4);
        chk_outs("latched_trig", 1, 0, 0, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk_outs("after_clear", 0, 0, 0, 0);
        chk("after_clear_status", {28'd0, trig_status}, 32'd0);
        latch_mode = 1'b0;
        repeat (10) tick();

        // Masked channel 0 never triggers.
        ch_enable = 4'b1110;
        pir_in[0] = 1'b1;
        repeat (6) tick();
        pir_in[0] = 1'b0;
        repeat (6) tick();
        chk("mask_alarm", {31'd0, alarm_active}, 32'd0);
        chk("mask_count", {16'd0, event_count}, 32'd4);
        chk("mask_status", {28'd0, trig_status}, 32'd0);
        ch_enable = 4'b1111;
        repeat (4) tick();

        // Disarm mid-ALARM.
        pir_in[1] = 1'b1;
        repeat (6) tick();
        pir_in[1] = 1'b0;
        tick();
        chk("disarm_pre", {31'd0, alarm_active}, 32'd1);
        chk("disarm_pre_count", {16'd0, event_count}, 32'd5);
        repeat (3) tick();
        arm = 1'b0;
        tick();
        chk_outs("disarm", 0, 0, 0, 0);
        chk("disarm_count", {16'd0, event_count}, 32'd5);
        chk("disarm_status", {28'd0, trig_status}, 32'h2);
        arm = 1'b1;
        repeat (9) tick();

        pir_in[2] = 1'b1;
        repeat (6) tick();
        pir_in[2] = 1'b0;
        tick();
        chk("rearm_alarm", {31'd0, alarm_active}, 32'd1);
        chk("rearm_count", {16'd0, event_count}, 32'd6);

        // Reset mid-ALARM.
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_outs("reset_mid", 0, 0, 0, 0);
        chk("reset_mid_count", {16'd0, event_count}, 32'd0);
        chk("reset_mid_status", {28'd0, trig_status}, 32'd0);
        rst = 1'b0;
        tick();
        pir_in[3] = 1'b1;
        repeat (6) tick();
        pir_in[3] = 1'b0;
        tick();
        chk("post_reset_alarm", {31'd0, alarm_active}, 32'd1);
        chk("post_reset_count", {16'd0, event_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pir_alarm_multi_core.md
PIR_ALARM_MULTI_CORE -- requirements
Module: pir_alarm_multi_core

Interface
REQ-001 Parameter NUM_CH, default 4, number of PIR input channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, cycles a synchronised input must hold a new level before it is accepted (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50000000, cycles the ALARM state lasts after the last accepted trigger (>=1).
REQ-004 Parameter COOLDOWN_CYCLES, default 10000000, cycles after ALARM during which triggers are ignored (>=1).
REQ-005 Parameter BUZZ_HALF, default 25000, buzzer half-period in cycles (>=1).
REQ-006 s00_axi_aclk  in  1  single clock; every register is updated on its rising edge.
REQ-007 s00_axi_areset  in  1  synchronous, active-high reset.
REQ-008 pir_in  in  NUM_CH  raw asynchronous PIR levels, one bit per channel.
REQ-009 ch_enable  in  NUM_CH  per-channel trigger mask; 1 means enabled.
REQ-010 arm  in  1  1 means armed; 0 forces DISARMED.
REQ-011 latch_mode  in  1  1 means hold expiry goes to LATCHED; 0 means hold expiry goes to COOLDOWN.
REQ-012 clear  in  1  single-cycle pulse; clears trig_status and exits LATCHED.
REQ-013 led  out  1  alarm indicator.
REQ-014 buzzer  out  1  square-wave drive.
REQ-015 enable_capture  out  1  camera capture enable.
REQ-016 alarm_active  out  1  high while in ALARM.
REQ-017 trig_status  out  NUM_CH  sticky per-channel trigger flags.
REQ-018 event_count  out  16  saturating count of accepted trigger events.

Function
REQ-019 Each pir_in bit SHALL pass through a 2-flop synchroniser; its sync output is called s.
REQ-020 Per channel, a debounce counter SHALL behave as follows: it resets to 0 whenever s == deb; it increments while s != deb; on the edge where it reaches DEBOUNCE_CYCLES, deb SHALL take s and the counter SHALL clear.
REQ-021 A channel trigger SHALL be the combinational rising edge of deb (deb & ~deb_q), ANDed with ch_enable; any = OR over channels.
REQ-022 Latency: with any=1 in IDLE, alarm_active SHALL be high exactly DEBOUNCE_CYCLES+2 edges after the edge that first samples pir_in high.
REQ-023 The FSM SHALL have the states DISARMED, IDLE, ALARM, COOLDOWN and LATCHED; arm=0 SHALL force DISARMED on the next edge from any state, with priority over all other transitions.
REQ-024 DISARMED SHALL go to IDLE when arm=1; IDLE SHALL go to ALARM when any=1.
REQ-025 On entry to ALARM, and on any=1 while in ALARM (retrigger), the hold counter SHALL load HOLD_CYCLES-1; otherwise it SHALL decrement.
REQ-026 When the hold counter is 0 and any=0, ALARM SHALL exit to LATCHED if latch_mode=1, else to COOLDOWN.
REQ-027 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles and then go to IDLE; triggers during COOLDOWN SHALL be ignored (not counted, status not set).
REQ-028 LATCHED SHALL go to IDLE on clear=1; triggers in LATCHED SHALL set trig_status but SHALL NOT count.
REQ-029 Accepted events: any=1 in IDLE or ALARM SHALL increment event_count by exactly 1 regardless of how many channels fire that cycle; event_count SHALL saturate at 0xFFFF and SHALL be retained across DISARMED.
REQ-030 trig_status[i] SHALL be set when channel i triggers in IDLE, ALARM or LATCHED, and cleared by clear; on simultaneous set and clear, set wins.
REQ-031 Outputs SHALL be registered: led = ALARM or LATCHED; enable_capture = alarm_active = ALARM.
REQ-032 buzzer SHALL be high on the first ALARM cycle and toggle every BUZZ_HALF cycles while in ALARM; buzzer SHALL be 0 in all other states, and a retrigger SHALL NOT restart the phase.

Reset
REQ-033 s00_axi_areset=1 SHALL, on the next edge, set FSM=DISARMED and zero all synchronisers, deb, counters, trig_status, event_count, led, buzzer, enable_capture and alarm_active; reset mid-ALARM SHALL abort immediately, and the block SHALL go to IDLE one edge after release if arm=1.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, COOLDOWN_CYCLES=8, BUZZ_HALF=2)
REQ-034 arm=1, pir_in[0] high for 20 cycles -> alarm_active rises 6 edges after the first sample and stays high 16 cycles after the trigger, then COOLDOWN for 8 cycles, then IDLE; event_count=1, trig_status=4'b0001; buzzer pattern 1,1,0,0,... during ALARM.
REQ-035 A pir_in[1] glitch of 3 cycles -> no trigger, event_count unchanged.
REQ-036 A retrigger on channel 2 at hold count 3 -> ALARM extended a further 16 cycles, event_count=2; pir_in[0] and pir_in[3] rising in the same cycle -> event_count +1 only, both status bits set.
REQ-037 latch_mode=1 -> LATCHED after hold: led=1, buzzer=0, enable_capture=0 until clear, then IDLE with trig_status=0.
REQ-038 ch_enable=4'b1110 with a channel-0 pulse -> no trigger; arm dropped mid-ALARM -> all outputs 0 next edge with event_count held; reset asserted mid-ALARM -> all outputs and event_count 0 next edge.
